// File: rtl/decay_scheduler.sv
// -----------------------------------------------------------------------------
// decay_scheduler
//
// Time-shares one potential-decay unit across a bank of NEURONS membrane
// potentials kept in an internal register file. On each accepted
// timestep_start the scheduler streams every stored potential (tagged with
// its address) to the decay unit. It writes the tagged results back into
// the file as they arrive, in any order, and then pulses done for one cycle.
// Potentials are passed through bit-exact; no arithmetic happens here.
//
// Ports
//   CLK            clock, everything on the rising edge
//   clear_n        asynchronous active-low reset
//   timestep_start one-cycle pass request (accepted only in IDLE)
//   decay_rate     rate captured at an accepted start, held on dec_rate
//   model          model captured at an accepted start, held on dec_model
//   cfg_we/addr/data  initial-potential write port (IDLE only, in-range only)
//   rd_addr/rd_data   registered readout, 1-cycle latency
//   dec_valid/ready/addr/potential/rate/model  request channel to decay unit
//   res_valid/addr/potential  tagged result channel from decay unit
//   busy           high while a pass is in ISSUE or DRAIN
//   done           one-cycle pass-complete pulse
//   overrun        sticky: a timestep_start arrived outside IDLE
//
// Request handshake: dec_valid/dec_ready follow strict valid/ready rules.
// A transfer happens on a rising edge where both are high. Once dec_valid
// is raised, it and every dec_* field hold stable until that transfer.
// The result channel has no back-pressure: every res_valid cycle is consumed.
// -----------------------------------------------------------------------------
module decay_scheduler #(
    parameter int NEURONS = 10,
    parameter int ADDR_W  = 4
) (
    input  logic              CLK,
    input  logic              clear_n,
    input  logic              timestep_start,
    input  logic [3:0]        decay_rate,
    input  logic [1:0]        model,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] dec_addr,
    output logic [31:0]       dec_potential,
    output logic [3:0]        dec_rate,
    output logic [1:0]        dec_model,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic [31:0]       res_potential,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    // Neuron count and last address, sized to the counters they are compared with.
    localparam logic [ADDR_W:0]   N_CNT     = (ADDR_W+1)'(NEURONS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [NEURONS];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [3:0]        rate_q, rate_d;
    logic [1:0]        model_q, model_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       rd_data_q, rd_data_d;

    logic              start_acc;
    logic              issue_fire;
    logic              issue_last;
    logic              res_ok;
    logic              cfg_ok;
    logic [ADDR_W:0]   cnt_total;
    logic              pass_complete;

    // ------------------------------------------------------------------
    // Qualified events
    // ------------------------------------------------------------------
    always_comb begin
        start_acc  = timestep_start && (state_q == S_IDLE);
        issue_fire = (state_q == S_ISSUE) && dec_ready;
        issue_last = issue_fire && (ptr_q == LAST_ADDR);
        // Results are only taken during a pass; out-of-range tags are dropped
        // and do not count toward completion.
        res_ok     = res_valid
                     && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                     && ({1'b0, res_addr} < N_CNT);
        cfg_ok     = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_addr} < N_CNT);
        // Completion includes this cycle's result. A result that lands on the
        // final issue cycle can then finish the pass without a DRAIN cycle.
        cnt_total     = cnt_q + {{ADDR_W{1'b0}}, res_ok};
        pass_complete = (cnt_total >= N_CNT);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (timestep_start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_last) begin
                    state_d = pass_complete ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pass_complete) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        dec_valid = (state_q == S_ISSUE);
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Pass bookkeeping: issue pointer, result counter, held config, overrun
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        rate_d    = rate_q;
        model_d   = model_q;
        overrun_d = overrun_q | (timestep_start && (state_q != S_IDLE));

        if (start_acc) begin
            ptr_d   = '0;
            cnt_d   = '0;
            rate_d  = decay_rate;
            model_d = model;
        end else begin
            // The pointer parks on the last address instead of wrapping.
            // This keeps dec_potential indexing a real entry at all times.
            if (issue_fire && !issue_last) begin
                ptr_d = ptr_q + 1'b1;
            end
            if (res_ok) begin
                cnt_d = cnt_total;
            end
        end
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            rate_q    <= '0;
            model_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rate_q    <= rate_d;
            model_q   <= model_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Potential file. Config writes happen only in IDLE and result writes
    // only in ISSUE/DRAIN, so the two write sources never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < NEURONS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cfg_ok) begin
            mem_q[cfg_addr] <= cfg_data;
        end else if (res_ok) begin
            mem_q[res_addr] <= res_potential;
        end
    end

    // ------------------------------------------------------------------
    // Registered readout. The read samples the file before any same-edge
    // write lands, so it returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_d = '0;
        if ({1'b0, rd_addr} < N_CNT) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    always_comb begin
        rd_data       = rd_data_q;
        dec_addr      = ptr_q;
        dec_potential = mem_q[ptr_q];
        dec_rate      = rate_q;
        dec_model     = model_q;
        overrun       = overrun_q;
    end

endmodule

// File: tb/tb_decay_scheduler.sv
module tb_decay_scheduler;

    localparam int NEURONS = 10;
    localparam int ADDR_W  = 4;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              CLK = 1'b0;
    logic              clear_n;
    logic              timestep_start;
    logic [3:0]        decay_rate;
    logic [1:0]        model;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [31:0]       cfg_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_addr;
    logic [31:0]       dec_potential;
    logic [3:0]        dec_rate;
    logic [1:0]        dec_model;
    logic              res_valid;
    logic [ADDR_W-1:0] res_addr;
    logic [31:0]       res_potential;
    logic              busy;
    logic              done;
    logic              overrun;

    always #5 CLK = ~CLK;

    decay_scheduler #(.NEURONS(NEURONS), .ADDR_W(ADDR_W)) dut (
        .CLK           (CLK),
        .clear_n       (clear_n),
        .timestep_start(timestep_start),
        .decay_rate    (decay_rate),
        .model         (model),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_addr      (dec_addr),
        .dec_potential (dec_potential),
        .dec_rate      (dec_rate),
        .dec_model     (dec_model),
        .res_valid     (res_valid),
        .res_addr      (res_addr),
        .res_potential (res_potential),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]       ref_mem [NEURONS];   // what the potential file should hold
    logic [ADDR_W-1:0] exp_q[$];            // expected issue order for a pass

    typedef struct {
        int                rel;             // first bench cycle it may be returned
        logic [ADDR_W-1:0] tag;
        logic [31:0]       val;
    } resp_t;
    resp_t pend_q[$];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [31:0]       exp;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bench decay unit: subtract the rate from the float exponent, flush to
    // signed zero when the exponent would underflow.
    function automatic logic [31:0] decay_fn(input logic [31:0] p, input logic [3:0] r);
        logic [7:0] e;
        e = p[30:23];
        if (e > {4'd0, r}) return {p[31], e - {4'd0, r}, p[22:0]};
        return {p[31], 31'd0};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        timestep_start = 1'b0;
        decay_rate     = '0;
        model          = '0;
        cfg_we         = 1'b0;
        cfg_addr       = '0;
        cfg_data       = '0;
        rd_addr        = '0;
        dec_ready      = 1'b0;
        res_valid      = 1'b0;
        res_addr       = '0;
        res_potential  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"},   rd_data, 32'd0);
        check({tag, "_dec_valid"}, {31'd0, dec_valid}, 32'd0);
        check({tag, "_dec_addr"},  {28'd0, dec_addr}, 32'd0);
        check({tag, "_dec_pot"},   dec_potential, 32'd0);
        check({tag, "_dec_rate"},  {28'd0, dec_rate}, 32'd0);
        check({tag, "_dec_model"}, {30'd0, dec_model}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy}, 32'd0);
        check({tag, "_done"},      {31'd0, done}, 32'd0);
        check({tag, "_overrun"},   {31'd0, overrun}, 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < NEURONS; a++) begin
            rd_addr = ADDR_W'(a);
            tick();
            check($sformatf("%s_file%0d", tag, a), rd_data, ref_mem[a]);
        end
    endtask

    task automatic load_random();
        for (int a = 0; a < NEURONS; a++) begin
            cfg_we   = 1'b1;
            cfg_addr = ADDR_W'(a);
            cfg_data = {1'($urandom_range(0, 1)), 8'($urandom_range(8, 250)), 23'($urandom)};
            ref_mem[a] = cfg_data;
            tick();
        end
        cfg_we = 1'b0;
    endtask

    // One full pass. mode 0: in-order results after 'lat' cycles;
    // mode 1: results held until all issued, returned in reverse, with one
    // out-of-range tag injected; mode 2: random order and timing.
    // ovr_at > 0 fires timestep_start plus a cfg write to address 3 at that cycle.
    task automatic run_pass(input string tag, input logic [3:0] rate, input int lat,
                            input int ready_pct, input int mode, input int ovr_at,
                            output int done_c);
        logic [1:0]        mdl;
        logic [ADDR_W-1:0] t;
        logic [ADDR_W-1:0] held_addr;
        logic [31:0]       held_pot;
        logic              stalled;
        logic              bad_sent;
        int                c, sent, exp_done, done_seen, idx;

        mdl = 2'($urandom_range(0, 3));
        exp_q.delete();
        pend_q.delete();
        for (int a = 0; a < NEURONS; a++) exp_q.push_back(ADDR_W'(a));

        decay_rate     = rate;
        model          = mdl;
        timestep_start = 1'b1;
        tick();
        timestep_start = 1'b0;
        decay_rate     = ~rate;
        model          = ~mdl;

        c = 1; sent = 0; exp_done = -1; done_seen = 0; done_c = -1;
        stalled = 1'b0; bad_sent = 1'b0; held_addr = '0; held_pot = '0;

        while (1) begin
            if (done === 1'b1) begin
                done_seen++;
                done_c = c;
                break;
            end
            if (c > 400) break;

            if (c == 1) begin
                check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
                check({tag, "_first_addr"}, {28'd0, dec_addr}, 32'd0);
            end
            if (c == 1 || c == 5) begin
                check({tag, "_dec_rate"},  {28'd0, dec_rate}, {28'd0, rate});
                check({tag, "_dec_model"}, {30'd0, dec_model}, {30'd0, mdl});
            end

            if (c == ovr_at) begin
                timestep_start = 1'b1;
                cfg_we         = 1'b1;
                cfg_addr       = 4'd3;
                cfg_data       = 32'hdeadbeef;
            end else begin
                timestep_start = 1'b0;
                cfg_we         = 1'b0;
            end

            // Request side
            if (dec_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_issue"}, {31'd0, dec_valid}, 32'd0);
                    dec_ready = 1'b0;
                end else begin
                    if (stalled) begin
                        check({tag, "_stall_addr"}, {28'd0, dec_addr}, {28'd0, held_addr});
                        check({tag, "_stall_pot"},  dec_potential, held_pot);
                    end
                    dec_ready = ($urandom_range(0, 99) < ready_pct);
                    if (dec_ready) begin
                        t = exp_q.pop_front();
                        check({tag, "_issue_addr"}, {28'd0, dec_addr}, {28'd0, t});
                        check({tag, "_issue_pot"},  dec_potential, ref_mem[t]);
                        pend_q.push_back('{rel: c + lat, tag: t, val: decay_fn(ref_mem[t], rate)});
                        stalled = 1'b0;
                    end else begin
                        stalled   = 1'b1;
                        held_addr = dec_addr;
                        held_pot  = dec_potential;
                    end
                end
            end else begin
                dec_ready = 1'($urandom_range(0, 1));
            end

            // Result side
            res_valid = 1'b0;
            idx = -1;
            if (mode == 0) begin
                if (pend_q.size() > 0 && pend_q[0].rel <= c) idx = 0;
            end else if (mode == 1) begin
                if (exp_q.size() == 0 && pend_q.size() > 0) begin
                    if (!bad_sent && pend_q.size() == NEURONS / 2) begin
                        bad_sent      = 1'b1;
                        res_valid     = 1'b1;
                        res_addr      = 4'd12;
                        res_potential = 32'h12345678;
                    end else begin
                        idx = pend_q.size() - 1;
                    end
                end
            end else begin
                if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                    idx = $urandom_range(0, pend_q.size() - 1);
                    if (pend_q[idx].rel > c) idx = -1;
                end
            end
            if (idx >= 0) begin
                res_valid        = 1'b1;
                res_addr         = pend_q[idx].tag;
                res_potential    = pend_q[idx].val;
                ref_mem[pend_q[idx].tag] = pend_q[idx].val;
                pend_q.delete(idx);
                sent++;
                if (sent == NEURONS) exp_done = c + 1;
            end

            tick();
            c++;
        end

        res_valid      = 1'b0;
        dec_ready      = 1'b0;
        timestep_start = 1'b0;
        cfg_we         = 1'b0;
        check({tag, "_done_seen"},  32'(done_seen), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
        check({tag, "_issued_all"}, 32'(exp_q.size()), 32'd0);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int dc;

        idle_inputs();
        for (int a = 0; a < NEURONS; a++) ref_mem[a] = '0;

        // Reset state, checked while reset is still asserted
        clear_n = 1'b1;
        #1;
        clear_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        clear_n = 1'b1;
        tick();

        // Table-driven config / readback
        vecs[0]  = '{we: 1'b1, addr: 4'd0,  data: 32'h41deb852, exp: 32'h0};
        vecs[1]  = '{we: 1'b1, addr: 4'd9,  data: 32'h411a147b, exp: 32'h0};
        vecs[2]  = '{we: 1'b1, addr: 4'd12, data: 32'hffffffff, exp: 32'h0};
        vecs[3]  = '{we: 1'b0, addr: 4'd0,  data: 32'h0, exp: 32'h41deb852};
        vecs[4]  = '{we: 1'b0, addr: 4'd9,  data: 32'h0, exp: 32'h411a147b};
        for (int a = 1; a <= 8; a++)
            vecs[4 + a] = '{we: 1'b0, addr: ADDR_W'(a), data: 32'h0, exp: 32'h0};
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].we) begin
                cfg_we   = 1'b1;
                cfg_addr = vecs[i].addr;
                cfg_data = vecs[i].data;
                if (vecs[i].addr < NEURONS) ref_mem[vecs[i].addr] = vecs[i].data;
                tick();
                cfg_we = 1'b0;
            end else begin
                rd_addr = vecs[i].addr;
                tick();
                check($sformatf("cfg_read%0d", vecs[i].addr), rd_data, vecs[i].exp);
            end
        end

        // Full pass, ready=1, 2-cycle results, rate 1
        run_pass("full", 4'd1, 2, 100, 0, 0, dc);
        check("full_done_at_13", 32'(dc), 32'd13);
        rd_addr = 4'd0;
        tick();
        check("full_file0_decayed", rd_data, 32'h415eb852);
        read_all("full");

        // Zero-latency results: minimum pass length, then back-to-back start
        load_random();
        run_pass("zerolat", 4'd2, 0, 100, 0, 0, dc);
        check("zerolat_done_at_11", 32'(dc), 32'(NEURONS + 1));
        run_pass("b2b", 4'd1, 1, 100, 0, 0, dc);
        read_all("b2b");

        // Backpressure with random latency
        load_random();
        run_pass("bp", 4'($urandom_range(1, 3)), $urandom_range(1, 3), 45, 0, 0, dc);
        read_all("bp");

        // Reverse-order results with an injected out-of-range tag
        load_random();
        run_pass("rev", 4'd3, 1, 70, 1, 0, dc);
        read_all("rev");

        // Overrun and cfg lockout mid-pass
        check("ovr_before", {31'd0, overrun}, 32'd0);
        run_pass("ovr", 4'd1, 1, 100, 0, 4, dc);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        read_all("ovr");

        // Random order/timing; overrun must stay sticky
        for (int r = 0; r < 3; r++) begin
            load_random();
            run_pass($sformatf("rnd%0d", r), 4'($urandom_range(0, 4)), $urandom_range(0, 4),
                     $urandom_range(30, 100), 2, 0, dc);
            read_all($sformatf("rnd%0d", r));
        end
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-pass: get into DRAIN by withholding every result
        load_random();
        decay_rate     = 4'd1;
        timestep_start = 1'b1;
        tick();
        timestep_start = 1'b0;
        dec_ready      = 1'b1;
        repeat (NEURONS + 2) tick();
        check("midrst_in_drain_busy", {31'd0, busy}, 32'd1);
        check("midrst_in_drain_valid", {31'd0, dec_valid}, 32'd0);
        #2;
        clear_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        idle_inputs();
        for (int a = 0; a < NEURONS; a++) ref_mem[a] = '0;
        tick();
        clear_n = 1'b1;
        tick();
        read_all("midrst");
        load_random();
        run_pass("after_rst", 4'd2, 2, 80, 0, 0, dc);
        read_all("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
